sound_seq: RTL and testbench
============================

Name: sound_seq

Overview:
- Parametrised event-driven tone sequencer for the game audio output, replacing the fixed four-event beeper.
- Each of N_EVT one-cycle game events starts a short program of up to STEPS notes. Each note has a period, counted in hsync edges, and a length, counted in frames.
- A single square-wave voice drives `audio`. Events are arbitrated by priority, and a higher-priority event pre-empts a lower one.
- Sits between the game logic (event pulses) and the audio pin, clocked with the VGA timing (hsync/vsync).

Parameters:
- N_EVT, 4, number of event inputs. Bit N_EVT-1 has the highest priority.
- STEPS, 4, maximum notes per program.
- DIV_W, 8, width of note period values and of the hsync divider.
- LEN_W, 4, width of note length values (frames).
- GAP, 1, when 1 audio is forced low during the last frame of every note (staccato).
- PERIOD, packed N_EVT*STEPS*DIV_W bits; note (e,s) at [(e*STEPS+s)*DIV_W +: DIV_W]. 0 = rest.
  - Default program: e0 = {100}, e1 = {200,150}, e2 = {250,200,150,100}, e3 = {150,0,150,200}.
- LEN, packed N_EVT*STEPS*LEN_W bits, same indexing. 0 = end-of-program marker.
  - Default program: e0 = {4,0,..}, e1 = {6,6,0,..}, e2 = {4,4,4,8}, e3 = {4,2,4,8}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- hsync  in  1  horizontal sync level; rising edge = divider tick
- vsync  in  1  vertical sync level; rising edge = frame tick
- evt  in  N_EVT  one-cycle event pulses
- mute  in  1  forces audio low; sequencing continues
- audio  out  1  square-wave output, registered
- busy  out  1  a program is playing
- cur_evt  out  max(1,$clog2(N_EVT))  index of the playing program; valid when busy

Behaviour:
- Reset (rst_n = 0 at a clk edge) clears all state:
  - audio = 0, busy = 0, cur_evt = 0.
  - step, frame and divider counters = 0.
  - hsync/vsync edge-detect registers = 0.
  - Reset mid-program aborts it silently; no pending state survives.
- Edge detection: prev_hsync and prev_vsync are registered each cycle. A tick is `sync && !prev_sync`.
- Arbitration, resolved each cycle:
  - w = highest set index of evt.
  - Accept when `!busy`, or when w >= cur_evt. An equal index restarts the program.
  - Lower-priority events while busy are dropped, not queued.
- On accept (next cycle):
  - busy = 1, cur_evt = w, step = 0, frame = 0, div = 0, audio = 0.
  - If LEN(w,0) = 0: busy stays 0 (empty program).
- Divider, on each hsync tick while busy:
  - If div == PERIOD(cur_evt,step): div = 0 and audio toggles.
  - Otherwise div = div + 1 (DIV_W bits, no overflow possible since div <= period).
  - Period 0 = rest: audio is held 0 and div stays 0.
- Effective output:
  - `audio_q & !mute & !(GAP && frame == LEN-1 && LEN > 1)`.
  - The output register is cleared whenever a note ends.
- Frame counter, on each vsync tick while busy:
  - If frame == LEN(cur_evt,step)-1: frame = 0 and the program advances one step; div = 0, audio = 0.
  - Otherwise frame = frame + 1.
- Program end: when step == STEPS-1, or LEN of the next step == 0, the program ends. busy = 0 and audio = 0 on the same edge.
- Simultaneous events:
  - Accept and a vsync/hsync tick in the same cycle: accept wins; the ticks are ignored that cycle.
  - Accept when busy, from a higher-priority event, pre-empts immediately with no glitch beyond audio = 0.
- Idle: audio = 0, counters frozen, ticks ignored.
- Latency:
  - evt to busy = 1 is 1 cycle.
  - The first audio toggle is (PERIOD+1) hsync ticks after accept.

Test Plan:
- Reset, then evt = 4'b0001, then 100 hsync ticks per frame:
  - busy rises 1 cycle later, cur_evt = 0.
  - audio toggles every 101 hsync ticks.
  - audio low during frame 3 (GAP).
  - busy falls at the 4th vsync edge.
- evt[1] (e1) playing, evt[0] pulsed mid-note: ignored. cur_evt stays 1 and the period sequence is 200 then 150. Ends after 12 frames.
- e1 playing, evt[3] pulsed:
  - Next cycle cur_evt = 3, step = 0, audio = 0.
  - Step 1 (period 0) holds audio at 0 for 2 frames.
  - Total 18 frames to busy = 0.
- evt = 4'b0110 in one cycle: cur_evt = 2. The program runs 4 steps of 4,4,4,8 frames, then busy = 0 after 20 vsync edges.
- mute = 1 during e2: audio stays 0, but busy deassertion timing is identical to the unmuted run.
- rst_n = 0 for one cycle mid-e3: all outputs 0 next cycle. A subsequent evt[0] plays normally from step 0.

Source files
------------

// File: rtl/sound_seq_if.sv
// Game-side connection of the tone sequencer: sync levels, event pulses, mute in;
// audio, busy and current program index out.
interface sound_seq_if #(
  parameter int unsigned N_EVT = 4,
  parameter int unsigned EVT_W = (N_EVT > 1) ? $clog2(N_EVT) : 1
);
  logic             hsync;
  logic             vsync;
  logic [N_EVT-1:0] evt;
  logic             mute;
  logic             audio;
  logic             busy;
  logic [EVT_W-1:0] cur_evt;

  modport master (output hsync, vsync, evt, mute, input audio, busy, cur_evt);
  modport slave  (input hsync, vsync, evt, mute, output audio, busy, cur_evt);
endinterface

// File: rtl/sound_seq.sv
// Priority-arbitrated, event-driven square-wave tone sequencer. Note periods are
// counted in hsync ticks, note lengths in vsync (frame) ticks.
module sound_seq #(
  parameter int unsigned N_EVT = 4,
  parameter int unsigned STEPS = 4,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 1,
  parameter logic [N_EVT*STEPS*DIV_W-1:0] PERIOD = {
    8'd200, 8'd150, 8'd0,   8'd150,
    8'd100, 8'd150, 8'd200, 8'd250,
    8'd0,   8'd0,   8'd150, 8'd200,
    8'd0,   8'd0,   8'd0,   8'd100},
  parameter logic [N_EVT*STEPS*LEN_W-1:0] LEN = {
    4'd8, 4'd4, 4'd2, 4'd4,
    4'd8, 4'd4, 4'd4, 4'd4,
    4'd0, 4'd0, 4'd6, 4'd6,
    4'd0, 4'd0, 4'd0, 4'd4}
) (
  input  logic        clk,
  input  logic        rst_n,
  sound_seq_if.slave  bus
);

  localparam int unsigned EVT_W  = (N_EVT > 1) ? $clog2(N_EVT) : 1;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic             prev_hsync, prev_vsync;
  logic             busy_q, busy_d;
  logic [EVT_W-1:0] cur_q, cur_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LEN_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d;
  logic             audio_q, audio_d;

  logic             hs_tick, vs_tick, accept, last_step, gap_d;
  logic [EVT_W-1:0] win;
  logic [LEN_W-1:0] cur_len, nxt_len;
  logic [DIV_W-1:0] cur_per;

  // Note table lookups; steps beyond the table read as end-of-program.
  function automatic logic [DIV_W-1:0] period_at(input logic [EVT_W-1:0] e,
                                                 input logic [STEP_W-1:0] s);
    int unsigned idx;
    idx = (32'(e) * STEPS + 32'(s)) * DIV_W;
    return PERIOD[idx +: DIV_W];
  endfunction

  function automatic logic [LEN_W-1:0] len_at(input logic [EVT_W-1:0] e,
                                              input int unsigned s);
    int unsigned idx;
    if (s >= STEPS) return '0;
    idx = (32'(e) * STEPS + s) * LEN_W;
    return LEN[idx +: LEN_W];
  endfunction

  assign hs_tick = bus.hsync && !prev_hsync;
  assign vs_tick = bus.vsync && !prev_vsync;

  // Highest set event index wins.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < N_EVT; i++) begin
      if (bus.evt[i]) win = EVT_W'(i);
    end
  end

  assign accept = (|bus.evt) && (!busy_q || win >= cur_q);

  assign cur_len   = len_at(cur_q, 32'(step_q));
  assign cur_per   = period_at(cur_q, step_q);
  assign last_step = (32'(step_q) == STEPS - 1) || (len_at(cur_q, 32'(step_q) + 1) == '0);

  // Sequencer next state: accept beats ticks; a frame-end overrides the divider.
  always_comb begin
    busy_d  = busy_q;
    cur_d   = cur_q;
    step_d  = step_q;
    frame_d = frame_q;
    div_d   = div_q;
    tone_d  = tone_q;
    if (accept) begin
      busy_d  = (len_at(win, 0) != '0);
      cur_d   = win;
      step_d  = '0;
      frame_d = '0;
      div_d   = '0;
      tone_d  = 1'b0;
    end else if (busy_q) begin
      if (hs_tick) begin
        if (cur_per == '0) begin
          div_d  = '0;
          tone_d = 1'b0;
        end else if (div_q == cur_per) begin
          div_d  = '0;
          tone_d = !tone_q;
        end else begin
          div_d  = div_q + DIV_W'(1);
        end
      end
      if (vs_tick) begin
        if (frame_q == cur_len - LEN_W'(1)) begin
          frame_d = '0;
          div_d   = '0;
          tone_d  = 1'b0;
          if (last_step) begin
            busy_d = 1'b0;
            step_d = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          frame_d = frame_q + LEN_W'(1);
        end
      end
    end
  end

  // Staccato gap and mute applied on the way into the output register.
  always_comb begin
    nxt_len = len_at(cur_d, 32'(step_d));
    gap_d   = (GAP != 0) && (nxt_len > LEN_W'(1)) && (frame_d == nxt_len - LEN_W'(1));
    audio_d = busy_d && tone_d && !bus.mute && !gap_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_hsync <= 1'b0;
      prev_vsync <= 1'b0;
      busy_q     <= 1'b0;
      cur_q      <= '0;
      step_q     <= '0;
      frame_q    <= '0;
      div_q      <= '0;
      tone_q     <= 1'b0;
      audio_q    <= 1'b0;
    end else begin
      prev_hsync <= bus.hsync;
      prev_vsync <= bus.vsync;
      busy_q     <= busy_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      frame_q    <= frame_d;
      div_q      <= div_d;
      tone_q     <= tone_d;
      audio_q    <= audio_d;
    end
  end

  assign bus.audio   = audio_q;
  assign bus.busy    = busy_q;
  assign bus.cur_evt = cur_q;

endmodule

// File: tb/tb_sound_seq.sv
// Directed bench for sound_seq: 100 hsync ticks per frame, rising audio edges logged
// by global hsync index within each run.
module tb_sound_seq;

  logic clk = 1'b0;
  logic rst_n;

  sound_seq_if #(.N_EVT(4)) bus ();

  sound_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int rise_at [0:7];
  int n_rise;
  int frame_highs [0:39];
  int hs_idx;
  int nframes;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_evt(input logic [3:0] e);
    bus.evt = e;
    cyc();
    bus.evt = 4'b0000;
  endtask

  // Run frames of 100 hsync pulses plus one vsync until busy drops or max_frames.
  // Optionally pulse inj_evt at the start of frame inj_frame and check the response.
  task automatic play(input int max_frames, input int inj_frame, input logic [3:0] inj_evt,
                      input int inj_cur, input int inj_aud, output int nf);
    logic prev;
    bit   done;
    n_rise = 0;
    hs_idx = 0;
    nf     = 0;
    done   = 1'b0;
    prev   = bus.audio;
    for (int f = 0; f < max_frames && !done; f++) begin
      if (f == inj_frame) begin
        pulse_evt(inj_evt);
        check("inj_cur_evt", int'(bus.cur_evt), inj_cur);
        check("inj_audio", int'(bus.audio), inj_aud);
        prev = bus.audio;
      end
      frame_highs[f] = 0;
      for (int h = 0; h < 100; h++) begin
        bus.hsync = 1'b1;
        cyc();
        bus.hsync = 1'b0;
        cyc();
        hs_idx++;
        if (bus.audio && !prev) begin
          if (n_rise < 8) rise_at[n_rise] = hs_idx;
          n_rise++;
        end
        if (bus.audio) frame_highs[f]++;
        prev = bus.audio;
      end
      bus.vsync = 1'b1;
      cyc();
      bus.vsync = 1'b0;
      cyc();
      nf++;
      prev = bus.audio;
      if (!bus.busy) done = 1'b1;
    end
  endtask

  initial begin
    bus.hsync = 1'b0;
    bus.vsync = 1'b0;
    bus.evt   = 4'b0000;
    bus.mute  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) cyc();
    check("rst_audio", int'(bus.audio), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cur_evt", int'(bus.cur_evt), 0);
    rst_n = 1'b1;
    cyc();

    // e0: single note, period 100, 4 frames, last frame gapped
    pulse_evt(4'b0001);
    check("e0_busy", int'(bus.busy), 1);
    check("e0_cur_evt", int'(bus.cur_evt), 0);
    check("e0_audio", int'(bus.audio), 0);
    play(40, -1, 4'b0000, 0, 0, nframes);
    check("e0_frames", nframes, 4);
    check("e0_rise0", rise_at[0], 101);
    check("e0_nrise", n_rise, 1);
    check("e0_gap_frame3", frame_highs[3], 0);
    check("e0_idle_audio", int'(bus.audio), 0);

    // e1 with a lower-priority e0 pulse mid-note (dropped, audio untouched)
    pulse_evt(4'b0010);
    check("e1_cur_evt", int'(bus.cur_evt), 1);
    play(40, 3, 4'b0001, 1, 1, nframes);
    check("e1_frames", nframes, 12);
    check("e1_nrise", n_rise, 3);
    check("e1_rise0", rise_at[0], 201);
    check("e1_rise1", rise_at[1], 751);
    check("e1_rise2", rise_at[2], 1053);

    // e1 pre-empted by e3 at the start of frame 2
    pulse_evt(4'b0010);
    play(40, 2, 4'b1000, 3, 0, nframes);
    check("e3_frames", nframes, 20);
    check("e3_nrise", n_rise, 4);
    check("e3_rise0", rise_at[0], 351);
    check("e3_rise1", rise_at[1], 951);
    check("e3_rise2", rise_at[2], 1401);
    check("e3_rest_highs", frame_highs[6] + frame_highs[7], 0);

    // two events in one cycle: e2 wins
    pulse_evt(4'b0110);
    check("e2_cur_evt", int'(bus.cur_evt), 2);
    play(40, -1, 4'b0000, 0, 0, nframes);
    check("e2_frames", nframes, 20);
    check("e2_nrise", n_rise, 6);
    check("e2_rise0", rise_at[0], 251);
    check("e2_rise1", rise_at[1], 601);
    check("e2_rise2", rise_at[2], 951);
    check("e2_rise3", rise_at[3], 1301);

    // muted e2: silent but identical length
    bus.mute = 1'b1;
    pulse_evt(4'b0100);
    play(40, -1, 4'b0000, 0, 0, nframes);
    check("mute_frames", nframes, 20);
    check("mute_nrise", n_rise, 0);
    bus.mute = 1'b0;

    // reset in the middle of e3
    pulse_evt(4'b1000);
    play(2, -1, 4'b0000, 0, 0, nframes);
    check("mid_e3_busy", int'(bus.busy), 1);
    check("mid_e3_audio", int'(bus.audio), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mid_rst_audio", int'(bus.audio), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_cur_evt", int'(bus.cur_evt), 0);
    pulse_evt(4'b0001);
    check("post_rst_busy", int'(bus.busy), 1);
    play(40, -1, 4'b0000, 0, 0, nframes);
    check("post_rst_frames", nframes, 4);
    check("post_rst_rise0", rise_at[0], 101);

    // equal-priority event restarts the program
    pulse_evt(4'b0001);
    play(40, 2, 4'b0001, 0, 0, nframes);
    check("restart_frames", nframes, 6);
    check("restart_nrise", n_rise, 2);
    check("restart_rise1", rise_at[1], 301);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
